// File: rtl/key_click_decoder.sv
// Groups debounced key presses separated by at most GAP_MAX idle cycles into one gesture
// and reports the press count as a one-cycle event when the gesture ends.
module key_click_decoder #(
  parameter int              CNT_W      = 25,
  parameter logic [CNT_W-1:0] GAP_MAX   = 25'd24_999_999,
  parameter logic [2:0]      MAX_CLICKS = 3'd4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_flag,
  output logic       click_valid,
  output logic [2:0] click_num,
  output logic       busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_gap_cnt;
  logic [CNT_W-1:0] w_gap_nxt;
  logic [2:0]       r_clicks;
  logic [2:0]       w_clicks_nxt;
  logic             w_report;
  logic [2:0]       w_report_num;
  logic             w_valid_nxt;
  logic [2:0]       w_num_nxt;
  logic             w_busy_nxt;

  // State, counters and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= ST_IDLE;
      r_gap_cnt   <= '0;
      r_clicks    <= 3'd0;
      click_valid <= 1'b0;
      click_num   <= 3'd0;
      busy        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gap_cnt   <= w_gap_nxt;
      r_clicks    <= w_clicks_nxt;
      click_valid <= w_valid_nxt;
      click_num   <= w_num_nxt;
      busy        <= w_busy_nxt;
    end
  end

  // Next-state logic; a press always wins over a coincident timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_gap_nxt    = r_gap_cnt;
    w_clicks_nxt = r_clicks;
    w_report     = 1'b0;
    w_report_num = r_clicks;
    case (r_state)
      ST_IDLE: begin
        if (key_flag) begin
          w_state_nxt  = ST_COUNT;
          w_clicks_nxt = 3'd1;
          w_gap_nxt    = '0;
        end else begin
          w_state_nxt  = ST_IDLE;
          w_clicks_nxt = 3'd0;
          w_gap_nxt    = '0;
        end
      end
      ST_COUNT: begin
        if (key_flag) begin
          if (r_clicks == (MAX_CLICKS - 3'd1)) begin
            w_state_nxt  = ST_IDLE;
            w_clicks_nxt = 3'd0;
            w_gap_nxt    = '0;
            w_report     = 1'b1;
            w_report_num = MAX_CLICKS;
          end else begin
            w_clicks_nxt = r_clicks + 3'd1;
            w_gap_nxt    = '0;
          end
        end else if (r_gap_cnt == GAP_MAX) begin
          w_state_nxt  = ST_IDLE;
          w_clicks_nxt = 3'd0;
          w_gap_nxt    = '0;
          w_report     = 1'b1;
          w_report_num = r_clicks;
        end else begin
          w_gap_nxt = r_gap_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_clicks_nxt = 3'd0;
        w_gap_nxt    = '0;
      end
    endcase
  end

  // Output logic; click_num holds its last reported value between reports.
  always_comb begin
    w_valid_nxt = w_report;
    w_busy_nxt  = (w_state_nxt == ST_COUNT);
    if (w_report) begin
      w_num_nxt = w_report_num;
    end else begin
      w_num_nxt = click_num;
    end
  end

endmodule

// File: tb/tb_key_click_decoder.sv
// Self-checking bench for key_click_decoder: directed test-plan steps followed by random
// presses, compared every cycle against a timestamp-based gesture model.
module tb_key_click_decoder;

  localparam int GAP  = 10;
  localparam int MAXC = 4;

  logic       sys_clk;
  logic       sys_rst;
  logic       key_flag;
  logic       click_valid;
  logic [2:0] click_num;
  logic       busy;

  int checks;
  int errors;
  int edge_n;
  int m_clicks;
  int m_last;
  logic       exp_valid;
  logic [2:0] exp_num;
  logic       exp_busy;
  int reports;
  int rpt_mark;
  int last_num;

  key_click_decoder #(
    .CNT_W     (4),
    .GAP_MAX   (4'd10),
    .MAX_CLICKS(3'd4)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_flag   (key_flag),
    .click_valid(click_valid),
    .click_num  (click_num),
    .busy       (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at edge %0d", tag, obs, expv, edge_n);
    end
  endtask

  // Gesture model built on press timestamps rather than a gap counter.
  task automatic model_edge(input logic kf, input logic rst);
    exp_valid = 1'b0;
    if (rst) begin
      m_clicks = 0;
      exp_num  = 3'd0;
    end else if (kf) begin
      if (m_clicks + 1 == MAXC) begin
        exp_valid = 1'b1;
        exp_num   = 3'(MAXC);
        m_clicks  = 0;
      end else begin
        m_clicks = m_clicks + 1;
      end
      m_last = edge_n;
    end else if (m_clicks > 0 && (edge_n - m_last) == GAP + 1) begin
      exp_valid = 1'b1;
      exp_num   = 3'(m_clicks);
      m_clicks  = 0;
    end
    exp_busy = (m_clicks > 0);
  endtask

  task automatic step(input logic kf, input logic rst);
    key_flag = kf;
    sys_rst  = rst;
    @(posedge sys_clk);
    edge_n++;
    model_edge(kf, rst);
    #1;
    chk("click_valid", {7'd0, click_valid}, {7'd0, exp_valid});
    chk("busy", {7'd0, busy}, {7'd0, exp_busy});
    chk("click_num", {5'd0, click_num}, {5'd0, exp_num});
    if (click_valid === 1'b1) begin
      reports++;
      last_num = int'(click_num);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic press();
    step(1'b1, 1'b0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    edge_n   = 0;
    m_clicks = 0;
    m_last   = 0;
    reports  = 0;
    last_num = 0;
    exp_num  = 3'd0;
    key_flag = 1'b0;
    sys_rst  = 1'b1;

    // Reset state
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    idle(3);

    // 1. Single press
    rpt_mark = reports;
    press();
    idle(15);
    chk("single_reports", 8'(reports - rpt_mark), 8'd1);
    chk("single_num", 8'(last_num), 8'd1);

    // 2. Double press 5 cycles apart
    rpt_mark = reports;
    press(); idle(4); press(); idle(15);
    chk("double_reports", 8'(reports - rpt_mark), 8'd1);
    chk("double_num", 8'(last_num), 8'd2);

    // 3. Gap boundary: 11 apart merges, 12 apart splits
    rpt_mark = reports;
    press(); idle(10); press(); idle(15);
    chk("gap11_reports", 8'(reports - rpt_mark), 8'd1);
    chk("gap11_num", 8'(last_num), 8'd2);
    rpt_mark = reports;
    press(); idle(11); press(); idle(15);
    chk("gap12_reports", 8'(reports - rpt_mark), 8'd2);
    chk("gap12_num", 8'(last_num), 8'd1);

    // 4. Four presses 3 apart, then a fifth 2 cycles after the report
    rpt_mark = reports;
    press(); idle(2); press(); idle(2); press(); idle(2); press();
    chk("max_immediate_valid", {7'd0, click_valid}, 8'd1);
    chk("max_immediate_num", {5'd0, click_num}, 8'd4);
    idle(1); press(); idle(15);
    chk("max_reports", 8'(reports - rpt_mark), 8'd2);
    chk("max_then_single_num", 8'(last_num), 8'd1);

    // 5. Press in the report cycle starts a new gesture
    rpt_mark = reports;
    press(); idle(11);
    chk("coinc_valid", {7'd0, click_valid}, 8'd1);
    press();
    chk("coinc_busy", {7'd0, busy}, 8'd1);
    idle(15);
    chk("coinc_reports", 8'(reports - rpt_mark), 8'd2);
    chk("coinc_num", 8'(last_num), 8'd1);

    // 6. Reset mid-gesture discards it
    rpt_mark = reports;
    press(); idle(2); press(); idle(3);
    step(1'b0, 1'b1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_num", {5'd0, click_num}, 8'd0);
    idle(15);
    chk("rst_no_report", 8'(reports - rpt_mark), 8'd0);
    press(); idle(15);
    chk("rst_next_num", 8'(last_num), 8'd1);

    // Random presses with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end
    idle(15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_click_decoder.md
Name: key_click_decoder

Overview:
Sits directly downstream of the key debounce stage and consumes its single-cycle press pulse, key_flag. It groups presses separated by no more than a programmable gap into one gesture. At the end of each gesture it reports the click count (single/double/triple/...) as a one-cycle event. Downstream control logic uses click_num to select different actions from one physical key.

Parameters:
GAP_MAX, 25'd24_999_999, maximum idle cycles allowed between presses of one gesture (0.5 s at 50 MHz); the gesture times out when the gap counter reaches this value.
CNT_W, 25, width of the gap counter; must satisfy 2**CNT_W > GAP_MAX.
MAX_CLICKS, 3'd4, click count at which the gesture is reported immediately without waiting for timeout; legal range 2..7.

Ports:
sys_clk  input  1  system clock, 50 MHz.
sys_rst  input  1  synchronous reset, active-high.
key_flag  input  1  debounced press pulse; one cycle high per press.
click_valid  output  1  one-cycle pulse; the gesture has ended and click_num is valid.
click_num  output  3  number of presses in the reported gesture, 1..MAX_CLICKS.
busy  output  1  high while a gesture is being collected (state COUNT).

Behaviour:
- Single clock (sys_clk). Reset is synchronous and active-high (sys_rst). All state changes on the rising edge of sys_clk.
- Reset values: state=IDLE, gap_cnt=0, clicks=0, click_valid=0, click_num=0, busy=0.
- Reset mid-gesture: discard the gesture. No click_valid is issued.
- Outputs are registered. busy is equivalent to (state==COUNT).
- click_valid defaults to 0 on every edge unless set by one of the rules below.
- IDLE state:
  - key_flag=1: go to COUNT, set clicks=1, set gap_cnt=0.
  - key_flag=0: stay in IDLE.
- COUNT state, key_flag=1 and clicks < MAX_CLICKS-1: clicks += 1, gap_cnt=0, stay in COUNT.
- COUNT state, key_flag=1 and clicks == MAX_CLICKS-1 (immediate report):
  - click_valid=1, click_num=MAX_CLICKS, go to IDLE, clicks=0, gap_cnt=0.
- COUNT state, key_flag=0 and gap_cnt < GAP_MAX: gap_cnt += 1.
- COUNT state, key_flag=0 and gap_cnt == GAP_MAX (timeout report):
  - click_valid=1, click_num=clicks, go to IDLE, clicks=0, gap_cnt=0.
- Simultaneous key_flag=1 and gap_cnt==GAP_MAX: the press wins. It is counted and the gap restarts; no timeout report that cycle.
- Timeout latency: if the last key_flag is sampled at edge k, click_valid is high in the cycle following edge k+GAP_MAX+1, i.e. GAP_MAX+1 cycles after that press.
- Immediate-report latency: click_valid is high in the cycle following the edge that samples the MAX_CLICKS-th press.
- key_flag=1 in the same cycle click_valid is high: the state is already IDLE, so a new gesture starts with clicks=1. No press is lost.
- click_num holds its last reported value between reports. It is meaningful only when qualified by click_valid.
- gap_cnt never exceeds GAP_MAX. clicks never exceeds MAX_CLICKS-1 while in COUNT.
- key_flag pulses longer than one cycle are out of contract; each high cycle counts as one press.

Test Plan (GAP_MAX=10, MAX_CLICKS=4 for simulation):
1. Single press: one key_flag pulse at edge k -> click_valid=1 for exactly one cycle after edge k+11, click_num=1; busy high from after edge k until after edge k+11.
2. Double press, presses 5 cycles apart -> one click_valid, click_num=2, 11 cycles after the second press; no report between the presses.
3. Gap boundary: second press exactly 11 cycles after the first (lands on gap_cnt==10) -> single report, click_num=2. Second press 12 cycles after the first -> two reports, click_num=1 then click_num=1.
4. Four presses 3 cycles apart -> click_valid in the cycle after the 4th press, click_num=4, no timeout report afterwards; a 5th press 2 cycles later starts a new gesture reported as click_num=1.
5. Press coinciding with a report cycle: key_flag high in the cycle click_valid=1 -> busy high next cycle, followed by a later report with click_num=1.
6. Reset mid-gesture: two presses, then sys_rst=1 for 1 cycle before timeout -> no click_valid; busy=0, click_num=0 after reset; the next press is reported as click_num=1.
